// File: rtl/dff_write_arbiter_pkg.sv
// Shared types and helpers for the DFF write arbiter.
// Holds the FSM encoding and the round-robin winner search.
package dff_arb_pkg;

  localparam int RR_MAX = 32;
  localparam int IDX_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ACK     = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set request at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(
    input logic [RR_MAX-1:0] req,
    input int                n,
    input int                ptr
  );
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k < n && !p.found && req[j]) begin
        p.found = 1'b1;
        p.idx   = IDX_W'(j);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/dff_write_arbiter_if.sv
// Requester-side bundle of the DFF write arbiter.
// The lock vector exists only when DFF_ARB_LOCK_EN is defined.
interface dff_write_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]         req;
    logic [N*W-1:0]       wdata;
`ifdef DFF_ARB_LOCK_EN
    logic [N-1:0]         lock;
`endif
    logic [N-1:0]         gnt;
    logic [N-1:0]         ack;
    logic [$clog2(N)-1:0] owner;
    logic                 busy;
    logic [W-1:0]         Q;

    modport master (
        output req, wdata,
`ifdef DFF_ARB_LOCK_EN
        output lock,
`endif
        input  gnt, ack, owner, busy, Q
    );

    modport slave (
        input  req, wdata,
`ifdef DFF_ARB_LOCK_EN
        input  lock,
`endif
        output gnt, ack, owner, busy, Q
    );
endinterface

// File: rtl/dff_write_arbiter_reg.sv
// W-bit register of D flip-flop cells with load enable.
// Synchronous active-high reset clears it to zero.
module dff_reg_w #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clock) begin
        if (reset)     q <= '0;
        else if (load) q <= d;
    end
endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter for a shared DFF register.
// Define DFF_ARB_LOCK_EN to let an owner hold the pointer via lock.
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    dff_write_arbiter_if.slave   io
);
    localparam int OW = $clog2(N);
    localparam logic [OW-1:0] LAST = OW'(N - 1);

    state_t        state, state_n;
    logic [OW-1:0] owner, owner_n;
    logic [OW-1:0] ptr, ptr_n;
    logic [N-1:0]  gnt, gnt_n;
    logic          load;
    logic          hold;
    pick_t         pick;
    logic [OW-1:0] win;

    assign pick = rr_pick(RR_MAX'(io.req), N, int'(ptr));
    assign win  = OW'(pick.idx);

`ifdef DFF_ARB_LOCK_EN
    assign hold = io.lock[owner];
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            owner <= '0;
            ptr   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            gnt   <= gnt_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        gnt_n   = gnt;
        load    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick.found) begin
                    owner_n      = win;
                    gnt_n        = '0;
                    gnt_n[win]   = 1'b1;
                    state_n      = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                load    = 1'b1;
                state_n = ST_ACK;
            end
            ST_ACK: begin
                gnt_n   = '0;
                state_n = ST_IDLE;
                if (!hold)
                    ptr_n = (owner == LAST) ? '0 : owner + OW'(1);
            end
            default: begin
                gnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // gnt still carries the owner's one-hot bit during ACK
    assign io.ack   = (state == ST_ACK) ? gnt : '0;
    assign io.gnt   = gnt;
    assign io.owner = owner;
    assign io.busy  = (state == ST_CAPTURE) || (state == ST_ACK);

    dff_reg_w #(.W(W)) u_reg (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .d     (io.wdata[int'(owner)*W +: W]),
        .q     (io.Q)
    );
endmodule

// File: tb/tb_dff_write_arbiter.sv
// Self-checking bench for dff_write_arbiter (N=4, W=8).
// Works with or without DFF_ARB_LOCK_EN.
module tb_dff_write_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dff_write_arbiter_if #(.N(N), .W(W)) io ();

    dff_write_arbiter #(.N(N), .W(W)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 capture, 2 ack
    int         m_phase = 0;
    int         m_owner = 0;
    int         m_ptr   = 0;
    logic [7:0] m_q     = '0;
    bit         started = 0;
    int         m_log[$];
    int         d_log[$];
    int         q_log[$];

    always @(posedge clock) begin
        started <= 1;
        if (reset) begin
            m_phase = 0; m_owner = 0; m_ptr = 0; m_q = '0;
        end else if (m_phase == 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (m_phase == 0 && io.req[i]) begin
                    m_owner = i;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            m_q = io.wdata[m_owner*W +: W];
            m_phase = 2;
        end else begin
            bit keep;
            keep = 0;
`ifdef DFF_ARB_LOCK_EN
            keep = io.lock[m_owner];
`endif
            if (!keep) m_ptr = (m_owner + 1) % N;
            m_log.push_back(m_owner);
            m_phase = 0;
        end
    end

    always @(negedge clock) begin
        if (started) begin
            logic [N-1:0] eg, ea;
            eg = (m_phase != 0) ? N'(1 << m_owner) : '0;
            ea = (m_phase == 2) ? N'(1 << m_owner) : '0;
            check("gnt",   32'(io.gnt),   32'(eg));
            check("ack",   32'(io.ack),   32'(ea));
            check("busy",  32'(io.busy),  32'(m_phase != 0));
            check("Q",     32'(io.Q),     32'(m_q));
            check("owner", 32'(io.owner), 32'(m_owner));
            for (int i = 0; i < N; i++)
                if (io.ack[i]) begin
                    d_log.push_back(i);
                    q_log.push_back(int'(io.Q));
                end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic check_logs(input string name, input int exp_a[],
                              input int exp_q[], input bit use_q);
        check({name, "_n"}, 32'(d_log.size()), 32'(exp_a.size()));
        check({name, "_mn"}, 32'(m_log.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < d_log.size())
                check({name, "_dut"}, 32'(d_log[i]), 32'(exp_a[i]));
            if (i < m_log.size())
                check({name, "_mdl"}, 32'(m_log[i]), 32'(exp_a[i]));
            if (use_q && i < q_log.size())
                check({name, "_q"}, 32'(q_log[i]), 32'(exp_q[i]));
        end
        d_log.delete(); m_log.delete(); q_log.delete();
    endtask

    initial begin
        int none[];
        none = new[0];
        io.req   = 4'hF;
        io.wdata = '0;
`ifdef DFF_ARB_LOCK_EN
        io.lock  = '0;
`endif
        // reset held with all requests pending
        tick(2);
        check("rst_Q",    32'(io.Q),    0);
        check("rst_gnt",  32'(io.gnt),  0);
        check("rst_ack",  32'(io.ack),  0);
        check("rst_busy", 32'(io.busy), 0);
        io.req = '0;
        reset  = 1'b0;
        tick(1);
        check("post_rst_busy", 32'(io.busy), 0);

        // single request
        io.req   = 4'b0100;
        io.wdata = 32'h00A5_0000;
        tick(1);
        check("single_gnt",  32'(io.gnt),  32'h4);
        check("single_ack0", 32'(io.ack),  0);
        tick(1);
        check("single_Q",    32'(io.Q),    32'hA5);
        check("single_ack",  32'(io.ack),  32'h4);
        io.req = '0;
        tick(1);
        check("single_busy", 32'(io.busy), 0);
        check("single_ack2", 32'(io.ack),  0);
        check_logs("single", '{2}, '{32'hA5}, 1);

        // wrap: pointer now 3
        io.req   = 4'b1001;
        io.wdata = 32'h3300_0030;
        tick(6);
        io.req = '0;
        check_logs("wrap", '{3, 0}, '{32'h33, 32'h30}, 1);
        tick(1);

        // fairness from pointer 0
        reset = 1'b1;
        tick(1);
        reset    = 1'b0;
        io.req   = 4'hF;
        io.wdata = 32'h1312_1110;
        tick(15);
        io.req = '0;
        check_logs("fair", '{0, 1, 2, 3, 0},
                   '{32'h10, 32'h11, 32'h12, 32'h13, 32'h10}, 1);
        tick(1);

        // reset on the CAPTURE edge aborts the write
        io.req = 4'b0010;
        tick(1);
        check("abort_gnt", 32'(io.gnt), 32'h2);
        reset = 1'b1;
        tick(1);
        check("abort_Q",    32'(io.Q),    0);
        check("abort_busy", 32'(io.busy), 0);
        check("abort_ack",  32'(io.ack),  0);
        reset = 1'b0;
        tick(3);
        io.req = '0;
        check_logs("abort", '{1}, '{32'h11}, 1);
        tick(1);

        // lock: pointer after owner 1 is 2
        io.req   = 4'b0011;
        io.wdata = 32'h0000_2120;
`ifdef DFF_ARB_LOCK_EN
        io.lock  = 4'b0001;
        tick(8);
        io.lock  = '0;
        tick(4);
        io.req = '0;
        check_logs("lock", '{0, 0, 0, 1}, none, 0);
`else
        tick(12);
        io.req = '0;
        check_logs("nolock", '{0, 1, 0, 1}, none, 0);
`endif
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
